// File: rtl/shift_register_ctrl_pkg.sv
// Shared types and constants for the shift-register sequencer.
//   SR_W      : width of the attached load/shift register
//   BIT_CNT_W : width of the per-word bit counter
//   NUM_REQ   : number of arbitrated requesters
//   state_e   : sequencer states
package shift_register_ctrl_pkg;

  localparam int SR_W      = 8;
  localparam int BIT_CNT_W = $clog2(SR_W);
  localparam int NUM_REQ   = 2;

  typedef enum logic [1:0] {
    ST_INIT,   // drive sr_reset for one cycle
    ST_IDLE,   // wait for a request, load the granted word
    ST_SHIFT,  // present bits MSB-first under sink backpressure
    ST_GAP     // idle spacing between words
  } state_e;

endpackage

// File: rtl/shift_register_ctrl_if.sv
// Bus bundle between the requesters, the sequencer, the shift register
// and the serial sink.
//   master : the sequencer (drives req_ready, sr_*, ser_* outputs)
//   slave  : the surrounding environment
interface shift_register_ctrl_if
  import shift_register_ctrl_pkg::*;
#(
  parameter int DATA_W = SR_W
);
  // requester side
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  // shift-register control and feedback
  logic                      sr_reset;
  logic                      sr_load;
  logic                      sr_shift;
  logic [DATA_W-1:0]         sr_parallel_in;
  logic [DATA_W-1:0]         sr_data_in;
  logic [DATA_W-1:0]         sr_q;
  // serial sink
  logic                      ser_valid;
  logic                      ser_data;
  logic                      ser_last;
  logic                      ser_src;
  logic                      ser_ready;

  modport master (
    input  req_valid, req_data, sr_q, ser_ready,
    output req_ready, sr_reset, sr_load, sr_shift, sr_parallel_in, sr_data_in,
           ser_valid, ser_data, ser_last, ser_src
  );

  modport slave (
    output req_valid, req_data, sr_q, ser_ready,
    input  req_ready, sr_reset, sr_load, sr_shift, sr_parallel_in, sr_data_in,
           ser_valid, ser_data, ser_last, ser_src
  );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin arbiter.
//   i_req_valid : per-requester request
//   i_rr_last   : index granted most recently
//   o_grant     : one-hot grant (zero when nobody requests)
//   o_grant_idx : index of the granted requester
//   o_grant_any : at least one requester is valid
module rr_arb2
  import shift_register_ctrl_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  logic               i_rr_last,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_grant_idx,
  output logic               o_grant_any
);

  always_comb begin
    o_grant_any = |i_req_valid;
    // Under contention the requester not served last wins; a lone
    // requester is granted regardless of history.
    o_grant_idx = (&i_req_valid) ? ~i_rr_last : i_req_valid[1];
    o_grant     = o_grant_any ? (NUM_REQ'(1) << o_grant_idx) : '0;
  end

endmodule

// File: rtl/shift_register_ctrl.sv
// Sequencer/arbiter for an external load/shift register. Grants one of two
// requesters, loads its word, then shifts it out MSB-first to a serial sink
// with backpressure, followed by GAP_CYCLES idle cycles.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   flush   : synchronous abort back to INIT
//   bus     : requester, shift-register and serial-sink signals (master side)
module shift_register_ctrl
  import shift_register_ctrl_pkg::*;
#(
  parameter int DATA_W     = SR_W,
  parameter int GAP_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  shift_register_ctrl_if.master  bus
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  if (DATA_W != SR_W) begin : g_width_check
    $error("shift_register_ctrl: DATA_W must equal the shift-register width");
  end

  state_e               r_state, w_next_state;
  logic [BIT_CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [GAP_W-1:0]     r_gap_cnt, w_gap_cnt_nxt;
  logic                 r_rr_last, w_rr_last_nxt;
  logic                 r_src, w_src_nxt;

  logic [NUM_REQ-1:0]   w_grant;
  logic                 w_grant_idx;
  logic                 w_grant_any;

  rr_arb2 u_arb (
    .i_req_valid (bus.req_valid),
    .i_rr_last   (r_rr_last),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_grant_any (w_grant_any)
  );

  // The register's default path reloads data_in, so feeding back sr_q holds it.
  assign bus.sr_data_in = bus.sr_q;
  assign bus.ser_data   = bus.sr_q[DATA_W-1];
  assign bus.ser_src    = r_src;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path infers a latch.
    w_next_state       = r_state;
    w_bit_cnt_nxt      = r_bit_cnt;
    w_gap_cnt_nxt      = r_gap_cnt;
    w_rr_last_nxt      = r_rr_last;
    w_src_nxt          = r_src;
    bus.req_ready      = '0;
    bus.sr_reset       = 1'b0;
    bus.sr_load        = 1'b0;
    bus.sr_shift       = 1'b0;
    bus.sr_parallel_in = '0;
    bus.ser_valid      = 1'b0;
    bus.ser_last       = 1'b0;

    case (r_state)
      ST_INIT: begin
        bus.sr_reset = 1'b1;
        w_next_state = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_grant_any && !flush) begin
          bus.req_ready      = w_grant;
          bus.sr_load        = 1'b1;
          bus.sr_parallel_in = w_grant_idx ? bus.req_data[DATA_W +: DATA_W]
                                           : bus.req_data[0 +: DATA_W];
          w_src_nxt          = w_grant_idx;
          w_rr_last_nxt      = w_grant_idx;
          w_bit_cnt_nxt      = '0;
          w_next_state       = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Suppressed during flush so an aborted word never completes a handshake.
        if (!flush) begin
          bus.ser_valid = 1'b1;
          bus.ser_last  = (r_bit_cnt == LAST_BIT);
          if (bus.ser_ready) begin
            bus.sr_shift  = 1'b1;
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            if (r_bit_cnt == LAST_BIT) begin
              w_gap_cnt_nxt = '0;
              w_next_state  = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            end
          end
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == GAP_LAST) w_next_state = ST_IDLE;
        else                       w_gap_cnt_nxt = r_gap_cnt + 1'b1;
      end
      default: w_next_state = ST_INIT;
    endcase

    // Abort overrides everything except reset; arbitration history survives.
    if (flush) begin
      w_next_state  = ST_INIT;
      w_bit_cnt_nxt = '0;
      w_gap_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_INIT;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_rr_last <= 1'b1;  // requester 0 wins the first contention
      r_src     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state   <= w_next_state;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_rr_last <= w_rr_last_nxt;
      r_src     <= w_src_nxt;
    end
  end

endmodule

// File: tb/tb_shift_register_ctrl.sv
// Self-checking bench for shift_register_ctrl: behavioural shift register,
// queue-based reference model of the serial stream, directed and random phases.
module tb_shift_register_ctrl;
  import shift_register_ctrl_pkg::*;

  localparam int DW  = SR_W;
  localparam int GAP = 1;

  typedef struct packed { logic d; logic last; logic src; } bit_t;
  typedef logic [DW:0] word_t;   // {src, word}
  typedef word_t wq_t[$];
  typedef bit gq_t[$];

  logic clk = 1'b0;
  logic reset_n;
  logic flush;

  shift_register_ctrl_if #(.DATA_W(DW)) bus ();

  shift_register_ctrl #(.DATA_W(DW), .GAP_CYCLES(GAP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Attached shift register: sync reset, load over shift, default loads data_in.
  logic [DW-1:0] sr_q = '0;
  always_ff @(posedge clk) begin
    if (bus.sr_reset)      sr_q <= '0;
    else if (bus.sr_load)  sr_q <= bus.sr_parallel_in;
    else if (bus.sr_shift) sr_q <= {sr_q[DW-2:0], 1'b0};
    else                   sr_q <= bus.sr_data_in;
  end
  assign bus.sr_q = sr_q;

  // Reference model: expected serial bits of the word in flight.
  bit_t m_q[$];
  int   m_gap;
  bit   m_init;
  bit   m_rr_last;

  // Requester / sink stimulus state.
  int            left [2];
  logic [DW-1:0] data [2];
  bit            rand_data, rand_flush, flush_arm;
  int            ready_mode, ready_phase;

  // Observed-traffic logs.
  word_t         word_log[$];
  bit            grant_log[$];
  logic [DW-1:0] acc;
  int            acc_n;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_init    = 1'b1;
    m_q.delete();
    m_gap     = 0;
    m_rr_last = 1'b1;
    acc_n     = 0;
  endtask

  // Called just after a falling edge: set this cycle's inputs.
  task automatic drive();
    for (int i = 0; i < 2; i++) bus.req_valid[i] = (left[i] > 0);
    bus.req_data = {data[1], data[0]};
    case (ready_mode)
      0:       bus.ser_ready = 1'b1;
      1:       begin bus.ser_ready = (ready_phase % 3 == 0); ready_phase++; end
      default: bus.ser_ready = ($urandom_range(0, 3) != 0);
    endcase
    flush = (flush_arm && m_q.size() == DW - 3) ||
            (rand_flush && $urandom_range(0, 99) == 0);
    if (flush) flush_arm = 1'b0;
  endtask

  // Compare outputs against the model, advance the model, wait one cycle.
  task automatic tick();
    bit            idle, gnt, g, e_sv, e_shift;
    logic [1:0]    e_rdy;
    logic [DW-1:0] e_pin;
    bit_t          h, nb;
    #1;
    idle    = !m_init && m_q.size() == 0 && m_gap == 0;
    gnt     = reset_n && idle && !flush && (|bus.req_valid);
    g       = (bus.req_valid == 2'b11) ? !m_rr_last : bus.req_valid[1];
    e_rdy   = gnt ? (2'b01 << g) : 2'b00;
    e_pin   = gnt ? data[g] : '0;
    e_sv    = (m_q.size() > 0) && !flush;
    h       = e_sv ? m_q[0] : '0;
    e_shift = e_sv && bus.ser_ready;

    check("sr_reset",       32'(bus.sr_reset),       32'(m_init));
    check("req_ready",      32'(bus.req_ready),      32'(e_rdy));
    check("sr_load",        32'(bus.sr_load),        32'(gnt));
    check("sr_shift",       32'(bus.sr_shift),       32'(e_shift));
    check("sr_parallel_in", 32'(bus.sr_parallel_in), 32'(e_pin));
    check("sr_data_in",     32'(bus.sr_data_in),     32'(sr_q));
    check("ser_valid",      32'(bus.ser_valid),      32'(e_sv));
    if (e_sv) begin
      check("ser_data", 32'(bus.ser_data), 32'(h.d));
      check("ser_last", 32'(bus.ser_last), 32'(h.last));
      check("ser_src",  32'(bus.ser_src),  32'(h.src));
    end

    if (bus.req_ready != 2'b00) grant_log.push_back(bus.req_ready[1]);
    if (bus.ser_valid && bus.ser_ready) begin
      acc = {acc[DW-2:0], bus.ser_data};
      acc_n++;
      if (bus.ser_last) begin
        check("bits_per_word", 32'(acc_n), 32'(DW));
        word_log.push_back({bus.ser_src, acc});
        acc_n = 0;
      end
    end
    if (flush || !reset_n) acc_n = 0;

    if (!reset_n) model_reset();
    else if (flush) begin
      m_init = 1'b1;
      m_q.delete();
      m_gap  = 0;
    end else if (m_init) m_init = 1'b0;
    else if (gnt) begin
      m_rr_last = g;
      for (int b = DW - 1; b >= 0; b--) begin
        nb.d    = data[g][b];
        nb.last = (b == 0);
        nb.src  = g;
        m_q.push_back(nb);
      end
    end else if (e_shift) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) m_gap = GAP;
    end else if (m_q.size() == 0 && m_gap > 0) m_gap--;

    if (gnt) begin
      left[g]--;
      if (rand_data) data[g] = DW'($urandom);
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) begin drive(); tick(); end
  endtask

  task automatic check_words(input string tag, input wq_t exp_w);
    check({tag, "_count"}, 32'(word_log.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < word_log.size(); i++)
      check(tag, 32'(word_log[i]), 32'(exp_w[i]));
    word_log.delete();
  endtask

  task automatic check_grants(input string tag, input gq_t exp_g);
    check({tag, "_count"}, 32'(grant_log.size()), 32'(exp_g.size()));
    for (int i = 0; i < exp_g.size() && i < grant_log.size(); i++)
      check(tag, 32'(grant_log[i]), 32'(exp_g[i]));
    grant_log.delete();
  endtask

  initial begin
    int k;
    left          = '{0, 0};
    data          = '{'0, '0};
    rand_data     = 1'b0;
    rand_flush    = 1'b0;
    flush_arm     = 1'b0;
    ready_mode    = 0;
    ready_phase   = 0;
    acc           = '0;
    flush         = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.ser_ready = 1'b0;
    reset_n       = 1'b1;
    model_reset();
    #1 reset_n = 1'b0;
    @(negedge clk);

    // Reset held, then released: one sr_reset cycle, then idle.
    run(3);
    reset_n = 1'b1;
    run(3);

    // Continuous contention: strict alternation starting with requester 0.
    left = '{4, 4};
    data = '{8'h0F, 8'hF0};
    run(90);
    check_grants("C_grants", '{0, 1, 0, 1, 0, 1, 0, 1});
    check_words("C_words", '{9'h00F, 9'h1F0, 9'h00F, 9'h1F0,
                             9'h00F, 9'h1F0, 9'h00F, 9'h1F0});

    // Single word 0xA5 with the sink always ready.
    left[0] = 1;
    data[0] = 8'hA5;
    run(14);
    check_words("A_words", '{9'h0A5});

    // Same word with sink backpressure 1,0,0,...
    ready_mode  = 1;
    ready_phase = 0;
    left[0]     = 1;
    run(32);
    check_words("B_words", '{9'h0A5});
    ready_mode = 0;
    grant_log.delete();

    // Flush after 3 bits of 0xC3; the other requester is served next.
    left      = '{1, 2};
    data      = '{8'h5A, 8'hC3};
    flush_arm = 1'b1;
    run(40);
    check_grants("D_grants", '{1, 0, 1});
    check_words("D_words", '{9'h05A, 9'h1C3});

    // Asynchronous reset in the middle of a word, then a clean 0x81.
    left[0] = 1;
    data[0] = 8'h55;
    k = 0;
    while (m_q.size() != 4 && k < 20) begin drive(); tick(); k++; end
    check("E_reach_mid_word", 32'(m_q.size()), 32'd4);
    reset_n = 1'b0;
    model_reset();
    drive();
    tick();
    run(1);
    reset_n = 1'b1;
    left[0] = 1;
    data[0] = 8'h81;
    run(16);
    check_words("E_words", '{9'h081});
    grant_log.delete();

    // Random traffic, backpressure and occasional flushes.
    rand_data  = 1'b1;
    rand_flush = 1'b1;
    ready_mode = 2;
    data[0]    = DW'($urandom);
    data[1]    = DW'($urandom);
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++)
        if (left[i] == 0 && $urandom_range(0, 9) == 0) left[i] = $urandom_range(1, 3);
      drive();
      tick();
    end
    rand_flush = 1'b0;
    left       = '{0, 0};
    run(60);
    check("F_drained", 32'(bus.ser_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
